// File: rtl/sine_voice_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : sine_voice_scheduler
//  Description : Time-multiplexes NVOICES phase-accumulator sine voices onto
//                one shared sine LUT and mixes them into one registered
//                16-bit sample per audio frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module sine_voice_scheduler #(
    parameter int NVOICES = 4,
    parameter int LUT_AW  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_voice,
    input  logic [15:0]       cfg_inc,
    input  logic              cfg_en,
    input  logic              cfg_sync,
    input  logic              ovr_clr,
    output logic              lut_rd,
    output logic [LUT_AW-1:0] lut_addr,
    input  logic [15:0]       lut_data,
    output logic [15:0]       dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    localparam logic [1:0] C_LAST_VOICE = 2'(NVOICES - 1);

    // Frame sequencing
    state_t             state_q, state_d;
    logic [1:0]         vidx_q, vidx_d;

    // Shadow configuration, writable at any time
    logic [15:0]        inc_sh_q [NVOICES];
    logic [15:0]        inc_sh_d [NVOICES];
    logic [NVOICES-1:0] en_sh_q, en_sh_d;
    logic [NVOICES-1:0] sync_sh_q, sync_sh_d;

    // Active configuration and phase, sampled at frame start
    logic [15:0]        inc_act_q [NVOICES];
    logic [15:0]        inc_act_d [NVOICES];
    logic [NVOICES-1:0] en_act_q, en_act_d;
    logic [15:0]        acc_q [NVOICES];
    logic [15:0]        acc_d [NVOICES];

    // Mixing datapath
    logic               rd_q, rd_d;
    logic [17:0]        sum_q, sum_d;
    logic [15:0]        dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               overrun_q, overrun_d;

    logic               frame_start;

    assign frame_start = sample_tick && (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign overrun     = overrun_q;

    // Frame FSM: one issue cycle per voice, one drain cycle, one output cycle
    always_comb begin
        state_d = state_q;
        vidx_d  = vidx_q;
        case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    state_d = ST_ISSUE;
                    vidx_d  = 2'd0;
                end
            end
            ST_ISSUE: begin
                if (vidx_q == C_LAST_VOICE) begin
                    state_d = ST_DRAIN;
                end else begin
                    vidx_d = vidx_q + 2'd1;
                end
            end
            ST_DRAIN: state_d = ST_OUT;
            ST_OUT:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Shadow registers; a write at frame start lands after sync-pending clears
    always_comb begin
        inc_sh_d  = inc_sh_q;
        en_sh_d   = en_sh_q;
        sync_sh_d = sync_sh_q;
        if (frame_start) begin
            sync_sh_d = '0;
        end
        if (cfg_we) begin
            inc_sh_d[cfg_voice]  = cfg_inc;
            en_sh_d[cfg_voice]   = cfg_en;
            sync_sh_d[cfg_voice] = cfg_sync;
        end
    end

    // Active config load at frame start, phase advance in each voice's issue slot
    always_comb begin
        inc_act_d = inc_act_q;
        en_act_d  = en_act_q;
        acc_d     = acc_q;
        if (frame_start) begin
            inc_act_d = inc_sh_q;
            en_act_d  = en_sh_q;
            for (int v = 0; v < NVOICES; v++) begin
                if (sync_sh_q[v]) begin
                    acc_d[v] = '0;
                end
            end
        end
        if ((state_q == ST_ISSUE) && en_act_q[vidx_q]) begin
            acc_d[vidx_q] = acc_q[vidx_q] + inc_act_q[vidx_q];
        end
    end

    // Shared LUT request: only enabled voices read, idle address is zero
    always_comb begin
        lut_rd   = 1'b0;
        lut_addr = '0;
        if ((state_q == ST_ISSUE) && en_act_q[vidx_q]) begin
            lut_rd   = 1'b1;
            lut_addr = acc_q[vidx_q][15 -: LUT_AW];
        end
    end

    // Mixer: sum the LUT words one cycle after each read, scale by 1/4 on output
    always_comb begin
        rd_d         = lut_rd;
        sum_d        = sum_q;
        dout_d       = dout_q;
        dout_valid_d = (state_q == ST_DRAIN);
        overrun_d    = overrun_q;
        if (frame_start) begin
            sum_d = '0;
        end else if (rd_q) begin
            sum_d = sum_q + {{2{lut_data[15]}}, lut_data};
        end
        if (state_q == ST_DRAIN) begin
            dout_d = sum_d[17:2];
        end
        if (ovr_clr) begin
            overrun_d = 1'b0;
        end
        // A dropped tick wins over a simultaneous clear
        if (sample_tick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            vidx_q       <= '0;
            inc_sh_q     <= '{default: '0};
            en_sh_q      <= '0;
            sync_sh_q    <= '0;
            inc_act_q    <= '{default: '0};
            en_act_q     <= '0;
            acc_q        <= '{default: '0};
            rd_q         <= 1'b0;
            sum_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            vidx_q       <= vidx_d;
            inc_sh_q     <= inc_sh_d;
            en_sh_q      <= en_sh_d;
            sync_sh_q    <= sync_sh_d;
            inc_act_q    <= inc_act_d;
            en_act_q     <= en_act_d;
            acc_q        <= acc_d;
            rd_q         <= rd_d;
            sum_q        <= sum_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

endmodule
`default_nettype wire
